// File: rtl/ssram_fifo_ctrl.sv
// FIFO sequencer for a dual-port synchronous RAM with a 2-entry output skid buffer.
// Push/pop use valid/ready handshakes and each side sustains one transfer per cycle.
module ssram_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+3)-1:0]   level,
    output logic                         ram_we,
    output logic [$clog2(DEPTH)-1:0]     ram_waddress,
    output logic [$clog2(DEPTH)-1:0]     ram_raddress,
    output logic [WIDTH-1:0]             ram_dataIn,
    input  logic [WIDTH-1:0]             ram_dataOut
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 3);

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    ram_used;
    logic             inflight;
    logic [1:0]       skid_cnt;
    logic             skid_head;
    logic [WIDTH-1:0] skid_mem [2];
    logic [AW-1:0]    waddr_q;
    logic [AW-1:0]    raddr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [2:0]       occ_after_pop;
    logic             push;
    logic             pop;
    logic             fetch;

    assign ram_used = wptr - rptr;
    assign wr_ready = rst_n & ~flush & (ram_used != PW'(DEPTH));
    assign push     = wr_valid & wr_ready;
    assign rd_valid = (skid_cnt != 2'd0);
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = skid_mem[skid_head];

    // Skid slots still claimed after this cycle's pop; a fetch needs one free slot.
    assign occ_after_pop = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fetch         = ~flush & (ram_used != '0) & (occ_after_pop < 3'd2);

    assign ram_we       = push;
    assign ram_waddress = push  ? wptr[AW-1:0] : waddr_q;
    assign ram_dataIn   = push  ? wr_data      : wdata_q;
    assign ram_raddress = fetch ? rptr[AW-1:0] : raddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
        end else begin
            if (push) begin
                waddr_q <= wptr[AW-1:0];
                wdata_q <= wr_data;
            end
            if (fetch) begin
                raddr_q <= rptr[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            inflight    <= 1'b0;
            skid_cnt    <= 2'd0;
            skid_head   <= 1'b0;
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            level       <= '0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            inflight  <= 1'b0;
            skid_cnt  <= 2'd0;
            skid_head <= 1'b0;
            level     <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (fetch) rptr <= rptr + 1'b1;
            inflight <= fetch;
            // Fetch gating guarantees skid_cnt <= 1 whenever a capture lands.
            if (inflight) skid_mem[skid_head ^ skid_cnt[0]] <= ram_dataOut;
            if (pop) skid_head <= ~skid_head;
            skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, pop};
            // ram_used + inflight + skid_cnt telescopes to level + push - pop.
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: tb/tb_ssram_fifo_ctrl.sv
// Randomized bench for ssram_fifo_ctrl against a queue-based reference model,
// with a behavioural dual-port RAM attached to the controller's RAM port.
module tb_ssram_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 3);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [LW-1:0]    level;
    logic             ram_we;
    logic [AW-1:0]    ram_waddress;
    logic [AW-1:0]    ram_raddress;
    logic [WIDTH-1:0] ram_dataIn;
    logic [WIDTH-1:0] ram_dataOut;

    logic [WIDTH-1:0] mem [DEPTH];

    int               tests = 0;
    int               fails = 0;
    logic [WIDTH-1:0] sb[$];
    int               push_cnt = 0;
    int               pop_cnt  = 0;
    int               wr_index = 0;
    logic             last_push;
    logic             last_pop;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddress] <= ram_dataIn;
        ram_dataOut <= mem[ram_raddress];
    end

    ssram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .level        (level),
        .ram_we       (ram_we),
        .ram_waddress (ram_waddress),
        .ram_raddress (ram_raddress),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, sample handshakes mid-cycle, update the model at the edge.
    task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        @(negedge clk);
        last_push = wr_valid & wr_ready;
        last_pop  = rd_valid & rd_ready;
        if (fl) check("flush_wr_ready", wr_ready, 0);
        else begin
            if (sb.size() < DEPTH)     check("wr_ready_room", wr_ready, 1);
            if (sb.size() == DEPTH + 2) check("wr_ready_full", wr_ready, 0);
        end
        if (sb.size() == 0) check("rd_valid_empty", rd_valid, 0);
        if (prev_stall && rd_valid) check("stall_stable", rd_data, prev_data);
        prev_stall = rd_valid & ~rd_ready;
        prev_data  = rd_data;
        check("ram_we", ram_we, last_push);
        if (last_push) begin
            check("ram_dataIn", ram_dataIn, wd);
            check("ram_waddress", ram_waddress, wr_index % DEPTH);
        end
        if (last_pop && sb.size() > 0) begin
            check("rd_data_order", rd_data, sb[0]);
            void'(sb.pop_front());
            pop_cnt++;
        end
        if (last_push) begin
            sb.push_back(wd);
            push_cnt++;
            wr_index++;
        end
        @(posedge clk);
        if (fl) begin
            sb.delete();
            wr_index   = 0;
            prev_stall = 1'b0;
        end
        #1;
        check("level", level, sb.size());
    endtask

    task automatic single_push(input logic [WIDTH-1:0] val);
        step(1'b1, val, 1'b0, 1'b0);
        check("lat_accept", last_push, 1);
        check("lat_valid_n", rd_valid, 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("lat_valid_n1", rd_valid, 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("lat_valid_n2", rd_valid, 1);
        check("lat_data", rd_data, val);
        step(1'b0, '0, 1'b1, 1'b0);
        check("lat_popped", last_pop, 1);
        check("lat_empty", rd_valid, 0);
    endtask

    initial begin
        int p0;
        int lvl0;
        int guard;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = '0;
        #2;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_waddr", ram_waddress, 0);
        check("rst_raddr", ram_raddress, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with back-to-back pushes and no pops.
        p0 = push_cnt;
        for (int i = 0; i < 36; i++) step(1'b1, 8'(push_cnt - p0), 1'b0, 1'b0);
        check("fill_accepted", push_cnt - p0, DEPTH + 2);
        check("fill_level", level, DEPTH + 2);
        check("fill_wr_ready", wr_ready, 0);

        // Push and pop together at full: push refused this cycle, space next cycle.
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        check("full_pp_push", last_push, 0);
        check("full_pp_pop", last_pop, 1);
        check("full_pp_ready_next", wr_ready, 1);

        p0 = pop_cnt;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("drain_pops", pop_cnt - p0, DEPTH + 1);
        check("drain_level", level, 0);

        single_push(8'hA5);

        // Streaming: push and pop every cycle.
        p0 = pop_cnt;
        lvl0 = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            if (i == 10) lvl0 = int'(level);
            if (i > 10) begin
                check("stream_level", level, lvl0);
                check("stream_valid", rd_valid, 1);
            end
        end
        check("stream_pops", pop_cnt - p0 >= 3 * DEPTH, 1);

        // Random traffic.
        for (int i = 0; i < 1000; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        guard = 0;
        while (sb.size() > 0 && guard < 40) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check("rand_drained", sb.size(), 0);

        // Flush with a concurrent push.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0);
        check("preflush_level", level, 20);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("flush_level", level, 0);
        check("flush_rd_valid", rd_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("postflush_valid", rd_valid, 0);
        end
        single_push(8'h11);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("after_11_valid", rd_valid, 0);
        end

        // Asynchronous reset in the middle of streaming.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rd_valid", rd_valid, 0);
        check("arst_wr_ready", wr_ready, 0);
        check("arst_level", level, 0);
        check("arst_ram_we", ram_we, 0);
        check("arst_waddr", ram_waddress, 0);
        check("arst_raddr", ram_raddress, 0);
        check("arst_rd_data", rd_data, 0);
        sb.delete();
        wr_index   = 0;
        prev_stall = 1'b0;
        wr_valid   = 1'b0;
        rd_ready   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_level", level, 0);
        check("rel_rd_valid", rd_valid, 0);
        single_push(8'h5A);
        for (int i = 0; i < 50; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
